// File: rtl/tpu_pkg.sv
// Shared definitions for the tiny TPU compute core.
//   DATA_W  : operand width (inputs and weights, unsigned)
//   ACC_W   : partial-sum / accumulator width
//   ADDR_W  : weight-memory address width carried in instruction[12:0]
//   opcode_e: instruction[15:13] encodings; any other value is a NOP
package tpu_pkg;

    localparam int DATA_W  = 16;
    localparam int ACC_W   = 32;
    localparam int ADDR_W  = 13;
    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        OP_NOP         = 3'b000,
        OP_LOAD_WEIGHT = 3'b001,
        OP_LOAD_INPUT  = 3'b010
    } opcode_e;

    // One multiply-accumulate step; the product and the sum both wrap at ACC_W.
    function automatic logic [ACC_W-1:0] mac(input logic [ACC_W-1:0] psum,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] w);
        return psum + (ACC_W'(a) * ACC_W'(w));
    endfunction

endpackage

// File: rtl/tpu_pe.sv
// One weight-stationary processing element of the systolic array.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_w_i      : capture w_i into the stationary weight at this edge
//   w_i           : weight from external weight memory
//   a_i           : activation from the left neighbour (or the array edge)
//   psum_i        : partial sum from the PE above (zero for the top row)
//   a_o           : registered activation passed to the right
//   psum_o        : registered partial sum passed down
// The MAC uses the weight held before this edge; a weight captured at an edge
// is first used by the following edge.
module tpu_pe
    import tpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_w_i,
    input  logic [DATA_W-1:0] w_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [ACC_W-1:0]  psum_i,
    output logic [DATA_W-1:0] a_o,
    output logic [ACC_W-1:0]  psum_o
);

    logic [DATA_W-1:0] w_q;
    logic [DATA_W-1:0] w_d;
    logic [DATA_W-1:0] a_q;
    logic [ACC_W-1:0]  psum_q;
    logic [ACC_W-1:0]  psum_d;

    always_comb begin
        w_d    = load_w_i ? w_i : w_q;
        psum_d = mac(psum_i, a_i, w_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_q    <= '0;
            a_q    <= '0;
            psum_q <= '0;
        end else begin
            w_q    <= w_d;
            a_q    <= a_i;
            psum_q <= psum_d;
        end
    end

    assign a_o    = a_q;
    assign psum_o = psum_q;

endmodule

// File: rtl/tpu_mmu_acc_core.sv
// Compute core of the tiny TPU: instruction decode, 2x2 weight-stationary
// systolic array, and one 2-slot accumulator per array column.
// Ports:
//   clk, reset (async, active-low)
//   instruction[15:13] opcode, [12:0] weight-memory address
//   valid, a_in1 (row 0, cycle t), a_in2 (row 1, caller-skewed to cycle t+1)
//   weight1..4 : weights for PE00, PE01, PE10, PE11
//   load_weight, load_input, base_address : registered decode
//   acc_out1/2 : bottom partial sum of column 0 / column 1
//   acc1_mem_0/1, acc2_mem_0/1, acc1_full, acc2_full : accumulator slots/flags
// Build option: define ACC_ADD_EN to make accumulator writes add onto the
// slot contents instead of overwriting them.
// Input handshake: valid has no ready companion; the core accepts one vector
// every cycle without backpressure and valid only tags which array outputs
// are written into the accumulators.
module tpu_mmu_acc_core
    import tpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               valid,
    input  logic [DATA_W-1:0]  a_in1,
    input  logic [DATA_W-1:0]  a_in2,
    input  logic [DATA_W-1:0]  weight1,
    input  logic [DATA_W-1:0]  weight2,
    input  logic [DATA_W-1:0]  weight3,
    input  logic [DATA_W-1:0]  weight4,
    output logic               load_weight,
    output logic               load_input,
    output logic [ADDR_W-1:0]  base_address,
    output logic [ACC_W-1:0]   acc_out1,
    output logic [ACC_W-1:0]   acc_out2,
    output logic [ACC_W-1:0]   acc1_mem_0,
    output logic [ACC_W-1:0]   acc1_mem_1,
    output logic [ACC_W-1:0]   acc2_mem_0,
    output logic [ACC_W-1:0]   acc2_mem_1,
    output logic               acc1_full,
    output logic               acc2_full
);

    // ---------------- decode ----------------
    logic              load_weight_q, load_weight_d;
    logic              load_input_q, load_input_d;
    logic [ADDR_W-1:0] base_address_q, base_address_d;
    logic [2:0]        opcode;

    assign opcode = instruction[INSTR_W-1:ADDR_W];

    always_comb begin
        load_weight_d  = 1'b0;
        load_input_d   = 1'b0;
        base_address_d = base_address_q;
        case (opcode)
            OP_LOAD_WEIGHT: begin
                load_weight_d  = 1'b1;
                base_address_d = instruction[ADDR_W-1:0];
            end
            OP_LOAD_INPUT: begin
                load_input_d   = 1'b1;
                base_address_d = instruction[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    // ---------------- systolic array ----------------
    logic [DATA_W-1:0] a00, a10;
    logic [DATA_W-1:0] a01_unused, a11_unused;
    logic [ACC_W-1:0]  ps00, ps01, ps10, ps11;

    tpu_pe u_pe00 (.clk_i(clk), .rst_ni(reset), .load_w_i(load_weight_q), .w_i(weight1),
                   .a_i(a_in1), .psum_i('0), .a_o(a00), .psum_o(ps00));
    tpu_pe u_pe01 (.clk_i(clk), .rst_ni(reset), .load_w_i(load_weight_q), .w_i(weight2),
                   .a_i(a00), .psum_i('0), .a_o(a01_unused), .psum_o(ps01));
    tpu_pe u_pe10 (.clk_i(clk), .rst_ni(reset), .load_w_i(load_weight_q), .w_i(weight3),
                   .a_i(a_in2), .psum_i(ps00), .a_o(a10), .psum_o(ps10));
    tpu_pe u_pe11 (.clk_i(clk), .rst_ni(reset), .load_w_i(load_weight_q), .w_i(weight4),
                   .a_i(a10), .psum_i(ps01), .a_o(a11_unused), .psum_o(ps11));

    // ---------------- valid pipe ----------------
    // Bit k is high in cycle t+k+1 for a vector presented at t. Column 0's
    // result is on ps10 during t+2 (bit 1), column 1's on ps11 during t+3 (bit 2).
    logic [2:0] vpipe_q, vpipe_d;

    assign vpipe_d = {vpipe_q[1:0], valid};

    // ---------------- accumulators ----------------
    logic [ACC_W-1:0] acc1_mem_q [2];
    logic [ACC_W-1:0] acc1_mem_d [2];
    logic [ACC_W-1:0] acc2_mem_q [2];
    logic [ACC_W-1:0] acc2_mem_d [2];
    logic             acc1_ptr_q, acc1_ptr_d, acc2_ptr_q, acc2_ptr_d;
    logic             acc1_full_q, acc1_full_d, acc2_full_q, acc2_full_d;

    // The flag copies the slot index being written: writing slot 1 completes
    // the pair, writing slot 0 starts a new one.
    always_comb begin
        acc1_mem_d  = acc1_mem_q;
        acc1_ptr_d  = acc1_ptr_q;
        acc1_full_d = acc1_full_q;
        if (vpipe_q[1]) begin
`ifdef ACC_ADD_EN
            acc1_mem_d[acc1_ptr_q] = acc1_mem_q[acc1_ptr_q] + ps10;
`else
            acc1_mem_d[acc1_ptr_q] = ps10;
`endif
            acc1_ptr_d  = ~acc1_ptr_q;
            acc1_full_d = acc1_ptr_q;
        end
    end

    always_comb begin
        acc2_mem_d  = acc2_mem_q;
        acc2_ptr_d  = acc2_ptr_q;
        acc2_full_d = acc2_full_q;
        if (vpipe_q[2]) begin
`ifdef ACC_ADD_EN
            acc2_mem_d[acc2_ptr_q] = acc2_mem_q[acc2_ptr_q] + ps11;
`else
            acc2_mem_d[acc2_ptr_q] = ps11;
`endif
            acc2_ptr_d  = ~acc2_ptr_q;
            acc2_full_d = acc2_ptr_q;
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_weight_q  <= 1'b0;
            load_input_q   <= 1'b0;
            base_address_q <= '0;
            vpipe_q        <= '0;
            acc1_mem_q[0]  <= '0;
            acc1_mem_q[1]  <= '0;
            acc2_mem_q[0]  <= '0;
            acc2_mem_q[1]  <= '0;
            acc1_ptr_q     <= 1'b0;
            acc2_ptr_q     <= 1'b0;
            acc1_full_q    <= 1'b0;
            acc2_full_q    <= 1'b0;
        end else begin
            load_weight_q  <= load_weight_d;
            load_input_q   <= load_input_d;
            base_address_q <= base_address_d;
            vpipe_q        <= vpipe_d;
            acc1_mem_q     <= acc1_mem_d;
            acc2_mem_q     <= acc2_mem_d;
            acc1_ptr_q     <= acc1_ptr_d;
            acc2_ptr_q     <= acc2_ptr_d;
            acc1_full_q    <= acc1_full_d;
            acc2_full_q    <= acc2_full_d;
        end
    end

    assign load_weight  = load_weight_q;
    assign load_input   = load_input_q;
    assign base_address = base_address_q;
    assign acc_out1     = ps10;
    assign acc_out2     = ps11;
    assign acc1_mem_0   = acc1_mem_q[0];
    assign acc1_mem_1   = acc1_mem_q[1];
    assign acc2_mem_0   = acc2_mem_q[0];
    assign acc2_mem_1   = acc2_mem_q[1];
    assign acc1_full    = acc1_full_q;
    assign acc2_full    = acc2_full_q;

endmodule

// File: tb/tb_tpu_mmu_acc_core.sv
// Testbench for tpu_mmu_acc_core: directed decode / MAC / accumulator cases,
// then randomized streaming with a mid-run reset, checked every cycle against
// a cycle-indexed reference model built from the documented latencies.
module tb_tpu_mmu_acc_core;
    import tpu_pkg::*;

    localparam int HN = 4096;

    // ---------------- clock / DUT ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       instruction;
    logic              valid;
    logic [DATA_W-1:0] a_in1, a_in2, weight1, weight2, weight3, weight4;
    logic              load_weight, load_input;
    logic [ADDR_W-1:0] base_address;
    logic [ACC_W-1:0]  acc_out1, acc_out2, acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1;
    logic              acc1_full, acc2_full;

    always #5 clk = ~clk;

    tpu_mmu_acc_core dut (
        .clk(clk), .reset(reset), .instruction(instruction), .valid(valid),
        .a_in1(a_in1), .a_in2(a_in2),
        .weight1(weight1), .weight2(weight2), .weight3(weight3), .weight4(weight4),
        .load_weight(load_weight), .load_input(load_input), .base_address(base_address),
        .acc_out1(acc_out1), .acc_out2(acc_out2),
        .acc1_mem_0(acc1_mem_0), .acc1_mem_1(acc1_mem_1),
        .acc2_mem_0(acc2_mem_0), .acc2_mem_1(acc2_mem_1),
        .acc1_full(acc1_full), .acc2_full(acc2_full)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;   // cycle index since the last reset release

    logic [2:0]        op_h [HN];
    logic [ADDR_W-1:0] ad_h [HN];
    logic              v_h  [HN];
    logic [15:0]       a1_h [HN];
    logic [15:0]       a2_h [HN];
    logic [15:0]       we_h [HN][4];  // weights held inside the array during cycle i
    logic [31:0]       ao1_h [HN];    // expected acc_out1 during cycle i
    logic [31:0]       ao2_h [HN];

    logic [15:0]       wdrv [4];      // weight bus value the bench drives
    logic [15:0]       m_w [4];
    logic [ADDR_W-1:0] m_base;
    logic [31:0]       m_slot [2][2];
    int                m_cnt [2];
    logic              exp_lw, exp_li;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] w);
        logic [31:0] p;
        p = {16'b0, a} * {16'b0, w};
        return p;
    endfunction

    function automatic logic [15:0] a1_at(input int i);
        return (i < 0) ? 16'd0 : a1_h[i];
    endfunction

    function automatic logic [15:0] a2_at(input int i);
        return (i < 0) ? 16'd0 : a2_h[i];
    endfunction

    function automatic logic [15:0] w_at(input int i, input int k);
        return (i < 0) ? 16'd0 : we_h[i][k];
    endfunction

    function automatic logic v_at(input int i);
        return (i < 0) ? 1'b0 : v_h[i];
    endfunction

    task automatic acc_write(input int acc, input logic [31:0] val);
        int s;
        s = m_cnt[acc] % 2;
`ifdef ACC_ADD_EN
        m_slot[acc][s] = m_slot[acc][s] + val;
`else
        m_slot[acc][s] = val;
`endif
        m_cnt[acc]++;
    endtask

    function automatic logic exp_full(input int acc);
        return (m_cnt[acc] > 0) && (m_cnt[acc] % 2 == 0);
    endfunction

    // Expected outputs of cycle n, derived from what was driven in earlier cycles.
    task automatic model_cycle();
        exp_lw = (n > 0) && (op_h[n-1] == 3'b001);
        exp_li = (n > 0) && (op_h[n-1] == 3'b010);
        if (exp_lw || exp_li) m_base = ad_h[n-1];
        for (int k = 0; k < 4; k++) we_h[n][k] = m_w[k];
        // column 0: row-0 product from t, row-1 product from t+1, seen at t+2
        ao1_h[n] = prod(a1_at(n-2), w_at(n-2, 0)) + prod(a2_at(n-1), w_at(n-1, 2));
        // column 1: element 0 reaches PE01 one cycle late, seen at t+3
        ao2_h[n] = prod(a1_at(n-3), w_at(n-2, 1)) + prod(a2_at(n-2), w_at(n-1, 3));
        if (v_at(n-3)) acc_write(0, ao1_h[n-1]);
        if (v_at(n-4)) acc_write(1, ao2_h[n-1]);
        if (exp_lw) for (int k = 0; k < 4; k++) m_w[k] = wdrv[k];
    endtask

    task automatic check_cycle();
        check("load_weight", 32'(load_weight), 32'(exp_lw));
        check("load_input", 32'(load_input), 32'(exp_li));
        check("base_address", 32'(base_address), 32'(m_base));
        check("acc_out1", acc_out1, ao1_h[n]);
        check("acc_out2", acc_out2, ao2_h[n]);
        check("acc1_mem_0", acc1_mem_0, m_slot[0][0]);
        check("acc1_mem_1", acc1_mem_1, m_slot[0][1]);
        check("acc2_mem_0", acc2_mem_0, m_slot[1][0]);
        check("acc2_mem_1", acc2_mem_1, m_slot[1][1]);
        check("acc1_full", 32'(acc1_full), 32'(exp_full(0)));
        check("acc2_full", 32'(acc2_full), 32'(exp_full(1)));
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; returns at the following falling edge.
    task automatic step(input logic [15:0] instr, input logic v,
                        input logic [15:0] x1, input logic [15:0] x2);
        instruction = instr;
        valid       = v;
        a_in1       = x1;
        a_in2       = x2;
        weight1     = wdrv[0];
        weight2     = wdrv[1];
        weight3     = wdrv[2];
        weight4     = wdrv[3];
        op_h[n] = instr[15:13];
        ad_h[n] = instr[12:0];
        v_h[n]  = v;
        a1_h[n] = x1;
        a2_h[n] = x2;
        model_cycle();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        n++;
        if (n >= HN) begin
            $display("FAIL history_overflow cycle=%0d got=%0d expected=<%0d", n, n, HN);
            $fatal(1, "history overflow");
        end
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        instruction = '0;
        valid       = 1'b0;
        a_in1       = '0;
        a_in2       = '0;
        #1;
        check("rst_load_weight", 32'(load_weight), 32'd0);
        check("rst_load_input", 32'(load_input), 32'd0);
        check("rst_base_address", 32'(base_address), 32'd0);
        check("rst_acc_out1", acc_out1, 32'd0);
        check("rst_acc_out2", acc_out2, 32'd0);
        check("rst_acc1_mem_0", acc1_mem_0, 32'd0);
        check("rst_acc1_mem_1", acc1_mem_1, 32'd0);
        check("rst_acc2_mem_0", acc2_mem_0, 32'd0);
        check("rst_acc2_mem_1", acc2_mem_1, 32'd0);
        check("rst_acc1_full", 32'(acc1_full), 32'd0);
        check("rst_acc2_full", 32'(acc2_full), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        n      = 0;
        m_base = '0;
        for (int k = 0; k < 4; k++) m_w[k] = '0;
        for (int a = 0; a < 2; a++) begin
            m_cnt[a]     = 0;
            m_slot[a][0] = '0;
            m_slot[a][1] = '0;
        end
        reset = 1'b1;
    endtask

    function automatic logic [15:0] pick_data();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'($urandom_range(0, 15));
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    function automatic logic [15:0] pick_instr();
        logic [2:0] op;
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r < 2)       op = 3'b001;
        else if (r < 4)  op = 3'b010;
        else if (r < 10) op = 3'b000;
        else             op = 3'($urandom_range(3, 7));
        return {op, 13'($urandom_range(0, 8191))};
    endfunction

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            for (int k = 0; k < 4; k++) wdrv[k] = pick_data();
            step(pick_instr(), ($urandom_range(0, 3) != 0), pick_data(), pick_data());
            next_cycle();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        instruction = '0;
        valid       = 1'b0;
        a_in1       = '0;
        a_in2       = '0;
        weight1     = '0;
        weight2     = '0;
        weight3     = '0;
        weight4     = '0;
        for (int k = 0; k < 4; k++) wdrv[k] = '0;
        #2;
        apply_reset();

        // decode, with weights 1..4 on the bus for both loads
        wdrv[0] = 16'd1; wdrv[1] = 16'd2; wdrv[2] = 16'd3; wdrv[3] = 16'd4;
        step(16'h2005, 1'b0, 16'd0, 16'd0); next_cycle();
        step(16'h4000, 1'b0, 16'd0, 16'd0);
        check("dec_lw_set", 32'(load_weight), 32'd1);
        check("dec_base_5", 32'(base_address), 32'd5);
        next_cycle();
        step(16'h2005, 1'b0, 16'd0, 16'd0);
        check("dec_li_set", 32'(load_input), 32'd1);
        check("dec_lw_clr", 32'(load_weight), 32'd0);
        next_cycle();
        step(16'h0000, 1'b0, 16'd0, 16'd0); next_cycle();
        step(16'hE123, 1'b0, 16'd0, 16'd0);
        check("dec_nop_lw", 32'(load_weight), 32'd0);
        check("dec_nop_li", 32'(load_input), 32'd0);
        check("dec_nop_base", 32'(base_address), 32'd5);
        next_cycle();
        step(16'h0000, 1'b0, 16'd0, 16'd0);
        check("dec_op7_base", 32'(base_address), 32'd5);
        next_cycle();

        // vectors (5,6), (7,8), (1,1) back to back, row 1 skewed by one cycle
        step(16'h0000, 1'b1, 16'd5, 16'd0); next_cycle();
        step(16'h0000, 1'b1, 16'd7, 16'd6); next_cycle();
        step(16'h0000, 1'b1, 16'd1, 16'd8);
        check("mac_col0_23", acc_out1, 32'd23);
        next_cycle();
        step(16'h0000, 1'b0, 16'd0, 16'd1);
        check("mac_col1_34", acc_out2, 32'd34);
        check("acc1_slot0_23", acc1_mem_0, 32'd23);
        check("acc1_no_early_full", 32'(acc1_full), 32'd0);
        next_cycle();
        step(16'h0000, 1'b0, 16'd0, 16'd0);
        check("acc1_slot1_31", acc1_mem_1, 32'd31);
        check("acc1_full_set", 32'(acc1_full), 32'd1);
        check("acc2_slot0_34", acc2_mem_0, 32'd34);
        check("acc2_no_early_full", 32'(acc2_full), 32'd0);
        next_cycle();
        step(16'h0000, 1'b0, 16'd0, 16'd0);
        check("acc2_slot1_46", acc2_mem_1, 32'd46);
        check("acc2_full_set", 32'(acc2_full), 32'd1);
        check("acc1_full_drop", 32'(acc1_full), 32'd0);
`ifdef ACC_ADD_EN
        check("acc1_wrap_slot0", acc1_mem_0, 32'd27);
`else
        check("acc1_wrap_slot0", acc1_mem_0, 32'd4);
`endif
        next_cycle();

        // all-ones operands: products and sums wrap modulo 2^32
        for (int k = 0; k < 4; k++) wdrv[k] = 16'hFFFF;
        step(16'h2000, 1'b0, 16'd0, 16'd0);
`ifdef ACC_ADD_EN
        check("acc2_wrap_slot0", acc2_mem_0, 32'd40);
`else
        check("acc2_wrap_slot0", acc2_mem_0, 32'd6);
`endif
        check("acc2_full_drop", 32'(acc2_full), 32'd0);
        next_cycle();
        step(16'h0000, 1'b0, 16'd0, 16'd0); next_cycle();
        step(16'h0000, 1'b1, 16'hFFFF, 16'd0); next_cycle();
        step(16'h0000, 1'b0, 16'd0, 16'hFFFF); next_cycle();
        step(16'h0000, 1'b0, 16'd0, 16'd0);
        check("wrap_col0", acc_out1, 32'hFFFC0002);
        next_cycle();
        step(16'h0000, 1'b0, 16'd0, 16'd0);
        check("wrap_col1", acc_out2, 32'hFFFC0002);
        next_cycle();

        // randomized streaming, reset mid-stream, then more streaming
        random_run(700);
        apply_reset();
        random_run(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
